// File: rtl/freq_pkg.sv
// Shared BCD definitions for the gated frequency counter.
package freq_pkg;

  localparam int DIG_W   = 4;
  localparam int MAX_DIG = 16;

  typedef logic [DIG_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Returns 9 in each of the low ndig digits; callers slice to their width.
  function automatic logic [DIG_W*MAX_DIG-1:0] all_nines(input int ndig);
    logic [DIG_W*MAX_DIG-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_DIG; i++) begin
      if (i < ndig) r[DIG_W*i +: DIG_W] = BCD_MAX;
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_bcd_counter_bcd_digit.sv
// One decade counter stage of the BCD accumulator.
module bcd_digit
  import freq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_in,
  input  logic       en,
  input  logic       clr,
  output bcd_digit_t q,
  output bcd_digit_t nxt,
  output logic       carry_out
);

  assign carry_out = inc_in & (q == BCD_MAX);
  // nxt is the pre-clear value, so the top can latch a result that includes this cycle's edge.
  assign nxt = inc_in ? ((q == BCD_MAX) ? '0 : q + 4'd1) : q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= nxt;
  end

endmodule

// File: rtl/freq_bcd_counter.sv
// Gated frequency counter with packed BCD result; FREQ_HOLD_EN adds a display-freeze hold input.
module freq_bcd_counter
  import freq_pkg::*;
#(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int NDIG        = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sig_in,
`ifdef FREQ_HOLD_EN
  input  logic                  hold,
`endif
  output logic [DIG_W*NDIG-1:0] bcd_out,
  output logic                  valid,
  output logic                  ovf
);

  localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TW-1:0] TC_VAL = TW'(GATE_CYCLES - 1);
  localparam logic [DIG_W*MAX_DIG-1:0] ALL9_FULL = all_nines(NDIG);
  localparam logic [DIG_W*NDIG-1:0] ALL9 = ALL9_FULL[DIG_W*NDIG-1:0];

  logic                  hold_eff;
  logic                  s1_reg, s2_reg, s3_reg;
  logic                  rise, tc, sat, update;
  logic [TW-1:0]         cnt_reg;
  logic                  win_ovf_reg;
  logic [NDIG-1:0]       inc, carry;
  logic [DIG_W*NDIG-1:0] accum_q, accum_nxt;

`ifdef FREQ_HOLD_EN
  assign hold_eff = hold;
`else
  assign hold_eff = 1'b0;
`endif

  assign rise   = s2_reg & ~s3_reg;
  assign tc     = (cnt_reg == TC_VAL);
  // A carry out of the top digit means the window count just passed all-9s.
  assign sat    = carry[NDIG-1];
  assign update = tc & ~hold_eff;
  assign inc[0] = rise;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    if (gi > 0) begin : g_chain
      assign inc[gi] = carry[gi-1];
    end
    bcd_digit u_digit (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc_in    (inc[gi]),
      .en        (~sat),
      .clr       (tc),
      .q         (accum_q[DIG_W*gi +: DIG_W]),
      .nxt       (accum_nxt[DIG_W*gi +: DIG_W]),
      .carry_out (carry[gi])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg      <= 1'b0;
      s2_reg      <= 1'b0;
      s3_reg      <= 1'b0;
      cnt_reg     <= '0;
      win_ovf_reg <= 1'b0;
      valid       <= 1'b0;
      bcd_out     <= '0;
      ovf         <= 1'b0;
    end else begin
      s1_reg      <= sig_in;
      s2_reg      <= s1_reg;
      s3_reg      <= s2_reg;
      cnt_reg     <= tc ? '0 : cnt_reg + TW'(1);
      win_ovf_reg <= tc ? 1'b0 : (win_ovf_reg | sat);
      valid       <= update;
      if (update) begin
        bcd_out <= sat ? ALL9 : accum_nxt;
        ovf     <= win_ovf_reg | sat;
      end
    end
  end

endmodule
